// File: rtl/next_pc_gen_pkg.sv
// Shared defaults and next-PC source-select encoding for the next-PC stage.
package next_pc_gen_pkg;

    localparam int unsigned PC_W_DEF      = 16;
    localparam int unsigned RAS_DEPTH_DEF = 4;
    localparam logic [15:0] TRAP_VEC_DEF  = 16'h0002;

    // Which source drives next_pc this cycle.
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_TGT,
        SEL_BR,
        SEL_SEQ
    } npc_sel_e;

endpackage

// File: rtl/next_pc_gen_ras_stack.sv
// Circular return-address stack: storage, top pointer and saturating count.
// A push that coincides with a pop is dropped; a push when full overwrites
// the oldest entry.
module next_pc_gen_ras_stack
    import next_pc_gen_pkg::*;
#(
    parameter int unsigned WIDTH = PC_W_DEF,
    parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] cnt_q;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointer wraps naturally because DEPTH is a power of two.
    assign top_idx   = ptr_q - PTR_W'(1);
    assign top       = mem_q[top_idx];
    assign count     = cnt_q;
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && !pop;
    assign underflow = pop && empty;
    assign overflow  = do_push && full;

    // Stack storage, pointer and occupancy update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (do_push) begin
            mem_q[ptr_q] <= push_data;
            ptr_q        <= ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC generation: priority mux over hold/return/target/branch/sequential,
// plus the return-address stack and its sticky error flag.
// Optional build macro NPC_TRAP_EN: ret on an empty stack redirects to TRAP_VEC
// instead of falling through to pc_in+1.
module next_pc_gen
    import next_pc_gen_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(TRAP_VEC_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PC_W-1:0]              pc_in,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [PC_W-1:0]              branch_off,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic [PC_W-1:0]              jump_target,
    output logic [PC_W-1:0]              next_pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_err
);

`ifdef NPC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] ret_pc;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_ovf;
    logic            ras_unf;
    logic            conflict;
    logic            ras_err_q;
    npc_sel_e        sel;

    assign seq_pc   = pc_in + PC_W'(1);
    assign br_pc    = pc_in + branch_off;
    assign ras_push = call && !stall;
    assign ras_pop  = ret && !stall;
    assign conflict = call && ret && !stall;
    assign ret_pc   = ras_empty ? TRAP_VEC : ras_top;

    next_pc_gen_ras_stack #(
        .WIDTH (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign ras_err   = ras_err_q;

    // Source select in priority order; an empty-stack ret falls to sequential
    // unless the trap redirect is built in.
    always_comb begin
        sel = SEL_SEQ;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            sel = (ras_empty && !TRAP_EN) ? SEL_SEQ : SEL_RET;
        end else if (call || jump) begin
            sel = SEL_TGT;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    // Next-PC data mux.
    always_comb begin
        next_pc = seq_pc;
        unique case (sel)
            SEL_HOLD: next_pc = pc_in;
            SEL_RET:  next_pc = ret_pc;
            SEL_TGT:  next_pc = jump_target;
            SEL_BR:   next_pc = br_pc;
            SEL_SEQ:  next_pc = seq_pc;
            default:  next_pc = seq_pc;
        endcase
    end

    // Sticky stack error, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_err_q <= 1'b0;
        end else if (ras_ovf || ras_unf || conflict) begin
            ras_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_next_pc_gen.sv
// Self-checking bench for next_pc_gen: queue-based reference stack, per-cycle
// compare on the falling edge, directed scenarios with literal expectations.
module tb_next_pc_gen;

    localparam int unsigned PC_W      = 16;
    localparam int unsigned RAS_DEPTH = 4;
    localparam logic [15:0] TRAP_VEC  = 16'h0002;
`ifdef NPC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc_in = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_off = '0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] jump_target = '0;
    logic [15:0] next_pc;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [15:0] model_q [$];
    bit          model_err = 1'b0;

    next_pc_gen #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH),
        .TRAP_VEC  (TRAP_VEC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump         (jump),
        .call         (call),
        .ret          (ret),
        .jump_target  (jump_target),
        .next_pc      (next_pc),
        .ras_count    (ras_count),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_err      (ras_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected next PC straight from the priority rules.
    function automatic logic [15:0] exp_npc();
        if (stall) return pc_in;
        if (ret) begin
            if (model_q.size() > 0) return model_q[$];
            return TRAP_EN ? TRAP_VEC : pc_in + 16'd1;
        end
        if (call || jump) return jump_target;
        if (branch_taken) return pc_in + branch_off;
        return pc_in + 16'd1;
    endfunction

    // Reference stack: newest at the back, oldest dropped from the front.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_q.delete();
            model_err <= 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (model_q.size() > 0) void'(model_q.pop_back());
                else model_err <= 1'b1;
                if (call) model_err <= 1'b1;
            end else if (call) begin
                if (model_q.size() == RAS_DEPTH) begin
                    void'(model_q.pop_front());
                    model_err <= 1'b1;
                end
                model_q.push_back(pc_in + 16'd1);
            end
        end
    end

    // Per-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check("next_pc", next_pc, exp_npc());
            check("ras_count", ras_count, model_q.size());
            check("ras_empty", ras_empty, model_q.size() == 0);
            check("ras_full", ras_full, model_q.size() == RAS_DEPTH);
            check("ras_err", ras_err, model_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pc, input logic st, input logic br,
                         input logic [15:0] off, input logic jp, input logic cl,
                         input logic rt, input logic [15:0] tgt);
        pc_in = pc; stall = st; branch_taken = br; branch_off = off;
        jump = jp; call = cl; ret = rt; jump_target = tgt;
    endtask

    task automatic randomize_inputs();
        drive(16'($urandom), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
              16'($urandom), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
              ($urandom_range(3) == 0), 16'($urandom));
    endtask

    // Asynchronous pulse between clock edges.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        // 1: reset with random inputs, then release between edges.
        randomize_inputs();
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        randomize_inputs();
        tick();
        reset = 1'b1;
        drive(16'h0010, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t1_next_pc", next_pc, 16'h0011);
        check("t1_count", ras_count, 0);
        check("t1_empty", ras_empty, 1);
        check("t1_err", ras_err, 0);
        tick();

        // 2: negative branch offset and sequential wrap.
        drive(16'h0020, 0, 1, 16'hFFFC, 0, 0, 0, 0);
        #1 check("t2_branch", next_pc, 16'h001C);
        tick();
        drive(16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        #1 check("t2_wrap", next_pc, 16'h0000);
        tick();

        // 3: nested call/return.
        do_reset();
        drive(16'h0100, 0, 0, 0, 0, 1, 0, 16'h0200);
        #1 check("t3_call1", next_pc, 16'h0200);
        tick(); check("t3_cnt1", ras_count, 1);
        drive(16'h0205, 0, 0, 0, 0, 1, 0, 16'h0300);
        #1 check("t3_call2", next_pc, 16'h0300);
        tick(); check("t3_cnt2", ras_count, 2);
        drive(16'h0301, 0, 0, 0, 0, 0, 1, 16'h0000);
        #1 check("t3_ret1", next_pc, 16'h0206);
        tick(); check("t3_cnt3", ras_count, 1);
        drive(16'h0207, 0, 0, 0, 0, 0, 1, 16'h0000);
        #1 check("t3_ret2", next_pc, 16'h0101);
        tick(); check("t3_cnt4", ras_count, 0);
        check("t3_err", ras_err, 0);

        // 4: overflow then drain, then underflow.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(16'h0010 + 16'(i), 0, 0, 0, 0, 1, 0, 16'h0040);
            tick();
        end
        check("t4_full", ras_full, 1);
        check("t4_err", ras_err, 1);
        check("t4_count", ras_count, 4);
        for (int k = 0; k < 4; k++) begin
            drive(16'h0050, 0, 0, 0, 0, 0, 1, 16'h0000);
            #1 check("t4_ret", next_pc, 16'h0015 - 16'(k));
            tick();
        end
        drive(16'h0060, 0, 0, 0, 0, 0, 1, 16'h0000);
        #1 check("t4_ret_empty", next_pc, TRAP_EN ? 16'h0002 : 16'h0061);
        tick(); check("t4_count_end", ras_count, 0);

        // 5: stall masks a conflict; unstalled conflict pops only.
        do_reset();
        drive(16'h0030, 0, 0, 0, 0, 1, 0, 16'h0070);
        tick();
        drive(16'h0070, 1, 0, 0, 0, 1, 1, 16'h0090);
        #1 check("t5_stall_pc", next_pc, 16'h0070);
        tick();
        check("t5_stall_cnt", ras_count, 1);
        check("t5_stall_err", ras_err, 0);
        drive(16'h0071, 0, 0, 0, 0, 1, 1, 16'h0090);
        #1 check("t5_conf_pc", next_pc, 16'h0031);
        tick();
        check("t5_conf_cnt", ras_count, 0);
        check("t5_conf_err", ras_err, 1);

        // 6: asynchronous reset with three entries stacked.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(16'h0400 + 16'(i), 0, 0, 0, 0, 1, 0, 16'h0500);
            tick();
        end
        check("t6_pre_cnt", ras_count, 3);
        drive(16'h0600, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("t6_async_cnt", ras_count, 0);
        check("t6_async_empty", ras_empty, 1);
        reset = 1'b1;
        tick();

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            if ($urandom_range(199) == 0) do_reset();
            tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
